// File: rtl/demux2_buf.sv
// demux2_buf: routes each input word into one of two DEPTH-entry FIFOs by in_sel; define DEMUX2_BUF_TRACE_EN for transfer tracing
module demux2_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [2][DEPTH];
  logic [AW-1:0]    r_rd  [2];
  logic [AW-1:0]    r_wr  [2];
  logic [AW:0]      r_cnt [2];
  logic [1:0]       w_valid, w_not_full, w_push, w_pop, w_out_ready;
  assign w_out_ready = {out1_ready, out0_ready};
  assign in_ready    = w_not_full[in_sel];
  assign out0_valid  = w_valid[0];
  assign out1_valid  = w_valid[1];
  assign out0_data   = r_mem[0][r_rd[0]];
  assign out1_data   = r_mem[1][r_rd[1]];
  // Per-queue status and handshake decode; a same-cycle pop never frees a slot for the push
  always_comb begin
    w_valid    = '0;
    w_not_full = '0;
    w_push     = '0;
    w_pop      = '0;
    for (int k = 0; k < 2; k++) begin
      w_valid[k]    = r_cnt[k] != '0;
      w_not_full[k] = r_cnt[k] != (AW+1)'(DEPTH);
      w_push[k]     = in_valid & w_not_full[k] & (in_sel == 1'(k));
      w_pop[k]      = w_valid[k] & w_out_ready[k];
    end
  end
  // Queue state: pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        r_rd[k]  <= '0;
        r_wr[k]  <= '0;
        r_cnt[k] <= '0;
        for (int i = 0; i < DEPTH; i++) r_mem[k][i] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (w_push[k]) begin
          r_mem[k][r_wr[k]] <= in_data;
          r_wr[k]           <= r_wr[k] + 1'b1;
        end
        if (w_pop[k]) r_rd[k] <= r_rd[k] + 1'b1;
        r_cnt[k] <= r_cnt[k] + (AW+1)'(w_push[k]) - (AW+1)'(w_pop[k]);
      end
    end
  end
`ifdef DEMUX2_BUF_TRACE_EN
  // Simulation trace of every transfer on either side
  always @(posedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready)
        $display("demux2_buf push sel=%0d data=%h occ0=%0d occ1=%0d", in_sel, in_data, r_cnt[0], r_cnt[1]);
      if (w_pop[0]) $display("demux2_buf pop port=0 data=%h", out0_data);
      if (w_pop[1]) $display("demux2_buf pop port=1 data=%h", out1_data);
    end
  end
`else
`endif
endmodule
